master_port: RTL and testbench
==============================

// Module: master_port
// PURPOSE
//  Initiator end of the serial system bus: accepts one parallel read/write request at a time from a
//  local device. Requests the bus from the arbiter, then shifts address and write data out LSB-first.
//  Collects serial read data back and returns it in parallel. One instance sits between each bus
//  master (CPU, UART bridge) and the arbiter/mux fabric that fronts the slave interfaces.
// PARAMETERS
//  ADDR_WIDTH  12    address bits sent per transaction
//  DATA_WIDTH  8     data bits per transfer
//  TIMEOUT     255   read-wait cycles before abort (used only when MASTER_TIMEOUT_EN defined)
// PORTS
//  clk        in   1           clock, all logic on posedge
//  rstn       in   1           synchronous, active-low reset
//  dev_valid  in   1           device request strobe; accepted only when dev_ready=1
//  dev_ready  out  1           port idle, can accept request
//  dev_wen    in   1           1=write, 0=read (sampled with dev_valid)
//  dev_addr   in   ADDR_WIDTH  target address
//  dev_wdata  in   DATA_WIDTH  write data
//  dev_rdata  out  DATA_WIDTH  read data, valid while dev_done=1
//  dev_done   out  1           1-cycle completion pulse
//  dev_err    out  1           1-cycle error flag with dev_done (timeout); constant 0 without macro
//  mreq       out  1           bus request to arbiter
//  mgrant     in   1           bus grant from arbiter
//  msplit     in   1           arbiter: current read transaction split, bus released
//  sready     in   1           selected slave idle/ready
//  bwdata     out  1           serial write bit
//  bmode      out  1           1=write, 0=read; held for whole transaction
//  bwvalid    out  1           bwdata valid
//  brdata     in   1           serial read bit
//  brvalid    in   1           brdata valid
// BEHAVIOUR
//  Reset: state=IDLE. dev_ready=1; dev_rdata=0; dev_done, dev_err, mreq, bwdata, bmode and bwvalid all 0.
//    Counters cleared. Reset mid-transaction aborts it silently: no dev_done, bus released next cycle.
//  All outputs registered. States: IDLE, REQ, ADDR, WDATA, RWAIT, SPLIT, RDATA, DONE.
//  IDLE: dev_ready=1. If dev_valid: latch addr/wdata/wen, dev_ready<=0, mreq<=1, go REQ.
//  REQ: hold mreq. When mgrant&&sready: go ADDR with cnt=0.
//  ADDR: bwvalid=1, bwdata=addr[cnt], bmode=wen each cycle for ADDR_WIDTH cycles, bits 0..ADDR_WIDTH-1.
//    First bit appears the cycle after the grant is seen. At cnt==ADDR_WIDTH-1: go WDATA if wen, else RWAIT.
//  WDATA: bwvalid=1, bwdata=wdata[cnt] for DATA_WIDTH contiguous cycles, directly after the last address bit.
//    Then go DONE.
//  RWAIT: bwvalid=0, mreq held. brvalid=1 -> capture brdata into rdata[0], cnt=1, go RDATA.
//    If msplit=1 and brvalid=0: mreq<=0, go SPLIT. Simultaneous msplit && brvalid: brvalid wins.
//  SPLIT: mreq=0, wait for brvalid (arbiter regrants the slave). On brvalid capture bit 0, go RDATA.
//  RDATA: each cycle with brvalid=1 capture rdata[cnt], cnt++. After bit DATA_WIDTH-1, go DONE.
//    A brvalid gap is tolerated: stay and keep waiting.
//  DONE: dev_done=1 for one cycle (dev_rdata=rdata on reads); mreq<=0, bwvalid<=0, bmode<=0; go IDLE.
//  Latency with grant and sready already high: write = 1+1+ADDR_WIDTH+DATA_WIDTH+1 cycles from dev_valid.
//  dev_valid while dev_ready=0 is ignored (no queueing). cnt is $clog2(max(ADDR_WIDTH,DATA_WIDTH))+1 bits.
// CONFIGURATION
//  MASTER_TIMEOUT_EN defined: a wait counter runs in RWAIT and SPLIT and is cleared on entry to RWAIT.
//    When it reaches TIMEOUT: go DONE with dev_err=1, dev_rdata=0, mreq<=0.
//  Not defined: no counter, dev_err tied 0, RWAIT/SPLIT wait indefinitely.
// STRUCTURE
//  Package bus_pkg: state encodings and MODE_READ/MODE_WRITE constants, shared with slave_interface.
//    Also shared with the arbiter.
//  One sub-module, serial_shifter: PISO for address/wdata plus SIPO for rdata. Has load, shift and cnt
//    ports; the FSM stays in master_port.
// TESTING
//  Write: addr=0x5A3, wdata=0xC6, grant/sready high -> bwvalid 20 cycles.
//    bwdata = 1,1,0,0,0,1,0,1,1,0,1,0 then 0,1,1,0,0,0,1,1; bmode=1; dev_done at cycle 23.
//  Read: addr=0x010, brvalid 8 cycles with bits of 0x9E -> dev_rdata=0x9E, dev_done=1, dev_err=0.
//  Grant delay: mgrant low 5 cycles after request -> mreq held, bwvalid stays 0 until the cycle after mgrant.
//  Split: msplit in RWAIT -> mreq drops next cycle. brvalid 10 cycles later carrying 0x3C -> dev_rdata=0x3C.
//  Reset: rstn low during ADDR bit 6 -> next cycle all outputs at reset values; no dev_done.
//    A new request then completes normally.
//  MASTER_TIMEOUT_EN, TIMEOUT=16: read with no brvalid -> dev_done=dev_err=1 after 16 wait cycles,
//    dev_rdata=0.

Source files
------------

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the serial system bus: master_port FSM state
// encodings, the bmode values, and a helper that sizes the bit counter.
// Imported by master_port, serial_shifter, slave_interface and the arbiter.
// -----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        WDATA,
        RWAIT,
        SPLIT,
        RDATA,
        DONE
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Bit counter wide enough to index the longer of the address or data field.
    function automatic int cnt_width(input int addr_width, input int data_width);
        return $clog2((addr_width > data_width) ? addr_width : data_width) + 1;
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// -----------------------------------------------------------------------------
// serial_shifter
// Datapath for master_port: holds the latched address and write data and
// presents them one bit at a time (PISO, LSB first), and assembles serial read
// data into a parallel word (SIPO). The bit counter lives here; sequencing is
// done by the FSM in master_port.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   load             latch addr/wdata, clear rdata and the counter
//   addr, wdata      parallel request fields to latch
//   cnt_clr          restart the counter at 0
//   shift            advance the counter by one
//   sel_data         bit_out selects wdata (1) or addr (0)
//   capture          store brdata into rdata[cnt]
//   brdata           serial read bit
//   cnt              current bit index
//   bit_out          addr[cnt] or wdata[cnt]
//   rdata            assembled read word
// -----------------------------------------------------------------------------
module serial_shifter
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = cnt_width(ADDR_WIDTH, DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  cnt_clr,
    input  logic                  shift,
    input  logic                  sel_data,
    input  logic                  capture,
    input  logic                  brdata,
    output logic [CNT_WIDTH-1:0]  cnt,
    output logic                  bit_out,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Index widths matched to each field so the selects are exact.
    localparam int AIW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam int DIW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            cnt     <= '0;
        end else begin
            if (load) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                rdata   <= '0;
            end else if (capture) begin
                rdata[cnt[DIW-1:0]] <= brdata;
            end

            if (load || cnt_clr) begin
                cnt <= '0;
            end else if (shift) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bit_out = sel_data ? wdata_q[cnt[DIW-1:0]] : addr_q[cnt[AIW-1:0]];

endmodule

// File: rtl/master_port.sv
// -----------------------------------------------------------------------------
// master_port
// Initiator end of the serial system bus. Accepts one parallel read/write
// request from a local device, requests the bus, shifts the address (and write
// data) out LSB first, collects serial read data and returns it in parallel.
// All outputs are registered.
// Configuration macro: MASTER_TIMEOUT_EN -- when defined, a read that sees no
// brvalid for TIMEOUT cycles in RWAIT/SPLIT completes with dev_err=1.
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   dev_valid/dev_ready       device request handshake
//   dev_wen, dev_addr,
//   dev_wdata                 request fields, sampled with dev_valid
//   dev_rdata, dev_done,
//   dev_err                   completion: 1-cycle pulse with read data / error
//   mreq, mgrant, msplit      arbiter request, grant, split indication
//   sready                    selected slave ready
//   bwdata, bmode, bwvalid    serial write bit, transaction mode, bit valid
//   brdata, brvalid           serial read bit and its valid
// -----------------------------------------------------------------------------
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dev_valid,
    output logic                  dev_ready,
    input  logic                  dev_wen,
    input  logic [ADDR_WIDTH-1:0] dev_addr,
    input  logic [DATA_WIDTH-1:0] dev_wdata,
    output logic [DATA_WIDTH-1:0] dev_rdata,
    output logic                  dev_done,
    output logic                  dev_err,
    output logic                  mreq,
    input  logic                  mgrant,
    input  logic                  msplit,
    input  logic                  sready,
    output logic                  bwdata,
    output logic                  bmode,
    output logic                  bwvalid,
    input  logic                  brdata,
    input  logic                  brvalid
);

    localparam int CW = cnt_width(ADDR_WIDTH, DATA_WIDTH);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("master_port: TIMEOUT must be at least 1");
    end

    state_t state, state_nxt;
    logic   wen_q;

    logic                  load, cnt_clr, shift, sel_data, capture;
    logic [CW-1:0]         cnt;
    logic                  bit_out;
    logic [DATA_WIDTH-1:0] rdata;

    logic                  dev_ready_nxt, dev_done_nxt, dev_err_nxt;
    logic                  mreq_nxt, bwdata_nxt, bmode_nxt, bwvalid_nxt;
    logic [DATA_WIDTH-1:0] dev_rdata_nxt;

    logic timeout_hit;  // wait budget exhausted this cycle
    logic timed_out;    // current transaction ended by timeout

    serial_shifter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CW)
    ) u_shifter (
        .clk      (clk),
        .rstn     (rstn),
        .load     (load),
        .addr     (dev_addr),
        .wdata    (dev_wdata),
        .cnt_clr  (cnt_clr),
        .shift    (shift),
        .sel_data (sel_data),
        .capture  (capture),
        .brdata   (brdata),
        .cnt      (cnt),
        .bit_out  (bit_out),
        .rdata    (rdata)
    );

`ifdef MASTER_TIMEOUT_EN
    localparam int WAIT_WIDTH = $clog2(TIMEOUT + 1);

    logic [WAIT_WIDTH-1:0] wait_cnt;
    logic                  wait_state;

    assign wait_state  = (state == RWAIT) || (state == SPLIT);
    assign timeout_hit = wait_state && !brvalid && (wait_cnt == WAIT_WIDTH'(TIMEOUT - 1));

    // ADDR always precedes RWAIT, so clearing there restarts the budget on entry.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state == ADDR) begin
                wait_cnt <= '0;
            end else if (wait_state && !brvalid) begin
                wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
            end

            if (state == IDLE) begin
                timed_out <= 1'b0;
            end else if (timeout_hit) begin
                timed_out <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timed_out   = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_nxt     = state;
        dev_ready_nxt = dev_ready;
        dev_done_nxt  = 1'b0;
        dev_err_nxt   = 1'b0;
        dev_rdata_nxt = dev_rdata;
        mreq_nxt      = mreq;
        bwdata_nxt    = 1'b0;
        bwvalid_nxt   = 1'b0;
        bmode_nxt     = bmode;
        load          = 1'b0;
        cnt_clr       = 1'b0;
        shift         = 1'b0;
        sel_data      = 1'b0;
        capture       = 1'b0;

        case (state)
            IDLE: begin
                if (dev_valid) begin
                    load          = 1'b1;
                    dev_ready_nxt = 1'b0;
                    mreq_nxt      = 1'b1;
                    bmode_nxt     = dev_wen;
                    state_nxt     = REQ;
                end
            end
            REQ: begin
                if (mgrant && sready) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                bwvalid_nxt = 1'b1;
                bwdata_nxt  = bit_out;
                bmode_nxt   = wen_q;
                if (cnt == CW'(ADDR_WIDTH - 1)) begin
                    cnt_clr   = 1'b1;
                    state_nxt = (wen_q == MODE_WRITE) ? WDATA : RWAIT;
                end else begin
                    shift = 1'b1;
                end
            end
            WDATA: begin
                sel_data    = 1'b1;
                bwvalid_nxt = 1'b1;
                bwdata_nxt  = bit_out;
                if (cnt == CW'(DATA_WIDTH - 1)) begin
                    state_nxt = DONE;
                end else begin
                    shift = 1'b1;
                end
            end
            RWAIT, SPLIT: begin
                // brvalid outranks both a simultaneous split and the timeout.
                if (brvalid) begin
                    capture   = 1'b1;
                    shift     = 1'b1;
                    state_nxt = RDATA;
                end else if (timeout_hit) begin
                    mreq_nxt  = 1'b0;
                    state_nxt = DONE;
                end else if (state == RWAIT && msplit) begin
                    mreq_nxt  = 1'b0;
                    state_nxt = SPLIT;
                end
            end
            RDATA: begin
                // A cycle without brvalid simply waits for the next bit.
                if (brvalid) begin
                    capture = 1'b1;
                    if (cnt == CW'(DATA_WIDTH - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            DONE: begin
                dev_done_nxt  = 1'b1;
                dev_err_nxt   = timed_out;
                dev_rdata_nxt = timed_out ? '0 : rdata;
                dev_ready_nxt = 1'b1;
                mreq_nxt      = 1'b0;
                bmode_nxt     = MODE_READ;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (!rstn) begin
            state     <= IDLE;
            wen_q     <= MODE_READ;
            dev_ready <= 1'b1;
            dev_rdata <= '0;
            dev_done  <= 1'b0;
            dev_err   <= 1'b0;
            mreq      <= 1'b0;
            bwdata    <= 1'b0;
            bmode     <= MODE_READ;
            bwvalid   <= 1'b0;
        end else begin
            state     <= state_nxt;
            dev_ready <= dev_ready_nxt;
            dev_rdata <= dev_rdata_nxt;
            dev_done  <= dev_done_nxt;
            dev_err   <= dev_err_nxt;
            mreq      <= mreq_nxt;
            bwdata    <= bwdata_nxt;
            bmode     <= bmode_nxt;
            bwvalid   <= bwvalid_nxt;
            if (load) begin
                wen_q <= dev_wen;
            end
        end
    end

endmodule

// File: tb/tb_master_port.sv
// -----------------------------------------------------------------------------
// tb_master_port
// Self-checking bench for master_port. Expected serial bits and completions are
// queued when a request is issued and compared by monitors as the DUT produces
// them. A vector table covers assorted reads/writes; hand-written sequences
// cover latency, grant delay, split, reset abort and (with MASTER_TIMEOUT_EN)
// the read timeout. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_master_port;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          dev_valid, dev_wen;
    logic [AW-1:0] dev_addr;
    logic [DW-1:0] dev_wdata, dev_rdata;
    logic          dev_ready, dev_done, dev_err;
    logic          mreq, mgrant, msplit, sready;
    logic          bwdata, bmode, bwvalid, brdata, brvalid;

    master_port #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .dev_valid (dev_valid),
        .dev_ready (dev_ready),
        .dev_wen   (dev_wen),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .dev_done  (dev_done),
        .dev_err   (dev_err),
        .mreq      (mreq),
        .mgrant    (mgrant),
        .msplit    (msplit),
        .sready    (sready),
        .bwdata    (bwdata),
        .bmode     (bmode),
        .bwvalid   (bwvalid),
        .brdata    (brdata),
        .brvalid   (brvalid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    typedef struct {
        logic b;
        logic m;
    } ser_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        bit            chk_rdata;
    } done_t;

    ser_t  exp_bits[$];
    done_t exp_done[$];
    ser_t  mon_s;
    done_t mon_d;

    always @(negedge clk) begin
        if (bwvalid === 1'b1) begin
            if (exp_bits.size() == 0) begin
                check("bwvalid_unexpected", exp_bits.size(), 1);
            end else begin
                mon_s = exp_bits.pop_front();
                check("bwdata", bwdata, mon_s.b);
                check("bmode", bmode, mon_s.m);
            end
        end
    end

    always @(negedge clk) begin
        if (dev_done === 1'b1) begin
            if (exp_done.size() == 0) begin
                check("dev_done_unexpected", exp_done.size(), 1);
            end else begin
                mon_d = exp_done.pop_front();
                if (mon_d.chk_rdata) check("dev_rdata", dev_rdata, mon_d.rdata);
                check("dev_err", dev_err, mon_d.err);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_dev_ready"}, dev_ready, 1);
        check({tag, "_dev_rdata"}, dev_rdata, 0);
        check({tag, "_dev_done"},  dev_done,  0);
        check({tag, "_dev_err"},   dev_err,   0);
        check({tag, "_mreq"},      mreq,      0);
        check({tag, "_bwdata"},    bwdata,    0);
        check({tag, "_bmode"},     bmode,     0);
        check({tag, "_bwvalid"},   bwvalid,   0);
    endtask

    // Called on a falling edge with the port idle; returns one cycle later.
    task automatic issue(input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] exp_rdata, input logic exp_err);
        check("dev_ready_before_issue", dev_ready, 1);
        for (int i = 0; i < AW; i++) exp_bits.push_back('{addr[i], wen});
        if (wen) for (int i = 0; i < DW; i++) exp_bits.push_back('{wdata[i], 1'b1});
        exp_done.push_back('{exp_rdata, exp_err, !wen});
        dev_valid = 1'b1;
        dev_wen   = wen;
        dev_addr  = addr;
        dev_wdata = wdata;
        @(negedge clk);
        dev_valid = 1'b0;
        dev_addr  = AW'($urandom);
        dev_wdata = DW'($urandom);
    endtask

    // Returns on the first falling edge after the address phase ends (RWAIT).
    task automatic wait_rwait();
        bit seen_hi = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bwvalid) seen_hi = 1'b1;
            else if (seen_hi) break;
        end
        check("reach_rwait", seen_hi && !bwvalid, 1);
    endtask

    task automatic drive_bits(input logic [DW-1:0] data, input bit gaps, input int start);
        for (int i = start; i < DW; i++) begin
            if (gaps && i == 3) begin
                brvalid = 1'b0;
                @(negedge clk);
            end
            brvalid = 1'b1;
            brdata  = data[i];
            @(negedge clk);
        end
        brvalid = 1'b0;
        brdata  = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (dev_done) break;
            @(negedge clk);
        end
        check("dev_done_seen", dev_done, 1);
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] resp;
        bit            gaps;
        bit            poke;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int first_bw, bw_count, done_at, n;

    initial begin
        vecs[0] = '{1'b1, 12'hFFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 12'h000, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[2] = '{1'b0, 12'h010, 8'h00, 8'h9E, 1'b0, 1'b0, 8'h9E};
        vecs[3] = '{1'b0, 12'hABC, 8'h00, 8'h01, 1'b1, 1'b0, 8'h01};
        vecs[4] = '{1'b0, 12'h800, 8'h00, 8'hFF, 1'b0, 1'b1, 8'hFF};
        vecs[5] = '{1'b1, 12'h001, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 12'h7FF, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 12'h555, 8'hAA, 8'h00, 1'b0, 1'b0, 8'h00};

        rstn = 1'b0; dev_valid = 1'b0; dev_wen = 1'b0; dev_addr = '0; dev_wdata = '0;
        mgrant = 1'b1; sready = 1'b1; msplit = 1'b0; brdata = 1'b0; brvalid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Directed write 0x5A3/0xC6: first bit on cycle 3, 20 bits, done on cycle 23.
        issue(1'b1, 12'h5A3, 8'hC6, 8'h00, 1'b0);
        check("wr_dev_ready_busy", dev_ready, 0);
        check("wr_mreq", mreq, 1);
        first_bw = -1; bw_count = 0; done_at = -1;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (bwvalid) begin
                bw_count++;
                if (first_bw < 0) first_bw = k;
            end
            if (dev_done) begin
                done_at = k;
                break;
            end
        end
        check("wr_first_bit_cycle", first_bw, 3);
        check("wr_bwvalid_cycles", bw_count, 20);
        check("wr_done_cycle", done_at, 23);
        @(negedge clk);
        check("wr_mreq_released", mreq, 0);

        // Vector table.
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0);
            if (vecs[i].poke) begin
                dev_valid = 1'b1;
                dev_wen   = ~vecs[i].wen;
                check("dev_ready_while_busy", dev_ready, 0);
                @(negedge clk);
                dev_valid = 1'b0;
            end
            if (!vecs[i].wen) begin
                wait_rwait();
                drive_bits(vecs[i].resp, vecs[i].gaps, 0);
            end
            wait_done(80);
        end

        // Grant delay: mreq held, no bits until the cycle after grant is seen.
        mgrant = 1'b0;
        issue(1'b1, 12'h3C5, 8'h5A, 8'h00, 1'b0);
        for (int j = 0; j < 5; j++) begin
            check("gd_mreq_held", mreq, 1);
            check("gd_bwvalid_low", bwvalid, 0);
            @(negedge clk);
        end
        mgrant = 1'b1;
        @(negedge clk);
        check("gd_bwvalid_after_grant", bwvalid, 0);
        @(negedge clk);
        check("gd_first_bit", bwvalid, 1);
        wait_done(60);

        // Split in RWAIT: mreq drops next cycle, read completes later.
        issue(1'b0, 12'h2A7, 8'h00, 8'h3C, 1'b0);
        wait_rwait();
        check("split_mreq_in_rwait", mreq, 1);
        msplit = 1'b1;
        @(negedge clk);
        msplit = 1'b0;
        check("split_mreq_drop", mreq, 0);
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            check("split_mreq_low", mreq, 0);
        end
        drive_bits(8'h3C, 1'b0, 0);
        wait_done(20);

        // msplit together with brvalid: brvalid wins, mreq stays up.
        issue(1'b0, 12'h1F0, 8'h00, 8'hB5, 1'b0);
        wait_rwait();
        msplit  = 1'b1;
        brvalid = 1'b1;
        brdata  = 1'b1;  // bit 0 of 0xB5
        @(negedge clk);
        msplit = 1'b0;
        check("split_vs_brvalid_mreq", mreq, 1);
        drive_bits(8'hB5, 1'b0, 1);
        wait_done(20);

        // Reset during address bit 6 aborts silently.
        issue(1'b1, 12'h6B4, 8'h33, 8'h00, 1'b0);
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bwvalid) n++;
            if (n == 7) break;
        end
        check("rst_reached_bit6", n, 7);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        exp_bits.delete();
        exp_done.delete();
        rstn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("abort_no_done", dev_done, 0);
        end
        issue(1'b1, 12'h123, 8'hA5, 8'h00, 1'b0);
        wait_done(60);

`ifdef MASTER_TIMEOUT_EN
        // Read with no brvalid: done with error after 16 wait cycles.
        issue(1'b0, 12'h0F0, 8'h00, 8'h00, 1'b1);
        wait_rwait();
        for (n = 0; n < 100; n++) begin
            if (dev_done) break;
            @(negedge clk);
        end
        check("timeout_wait_cycles", n, 16);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        check("bits_outstanding", exp_bits.size(), 0);
        check("done_outstanding", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
